// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and the fetch queue entry type.
package cpu_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0001_0000;
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            fault;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: redirect, instruction-memory and issue-queue signals of the fetch stage.
interface fetch_unit_if;
    import cpu_pkg::*;
    logic            override;
    logic [XLEN-1:0] newpc;
    logic            imem_valid;
    logic            imem_ready;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic            out_fault;
    modport master (
        input  override, newpc, imem_ready, imem_rdata, out_ready,
        output imem_valid, imem_addr, out_valid, out_instr, out_pc, out_fault
    );
    modport slave (
        output override, newpc, imem_ready, imem_rdata, out_ready,
        input  imem_valid, imem_addr, out_valid, out_instr, out_pc, out_fault
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry shift FIFO of fetch entries; head is zero while empty.
module fetch_queue
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_entry,
    output logic [1:0]   o_count_next,
    output logic         o_valid,
    output fetch_entry_t o_head
);
    fetch_entry_t r_mem [2];
    logic [1:0]   r_count;
    logic         w_pop;
    logic         w_widx;

    assign w_pop        = i_pop & (r_count != 2'd0);
    assign w_widx       = r_count[1] | (r_count[0] & ~w_pop);
    assign o_count_next = i_flush ? 2'd0 : r_count + {1'b0, i_push} - {1'b0, w_pop};
    assign o_valid      = r_count != 2'd0;
    assign o_head       = o_valid ? r_mem[0] : '0;

    always_ff @(posedge clk) begin
        r_count <= rst ? 2'd0 : o_count_next;
        if (w_pop) r_mem[0] <= r_mem[1];
        if (i_push & ~i_flush) r_mem[w_widx] <= i_entry;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, single-outstanding imem request, redirect kill and
// misaligned-target fault handling in front of a 2-entry instruction queue.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input logic         clk,
    input logic         rst,
    fetch_unit_if.master bus
);
    localparam int XLEN = cpu_pkg::XLEN;

    logic            r_valid, r_kill, r_stopped, r_fpend;
    logic [XLEN-1:0] r_addr, r_pc;
    logic            w_resp, w_hold, w_mis, w_take, w_fpush, w_pop, w_stopped_nx, w_head_valid;
    logic [1:0]      w_count_nx;
    logic [XLEN-1:0] w_pc_nx;
    cpu_pkg::fetch_entry_t w_entry, w_head;

    assign w_resp       = r_valid & bus.imem_ready;
    assign w_hold       = r_valid & ~bus.imem_ready;
    assign w_mis        = bus.override & (bus.newpc[1:0] != 2'b00);
    assign w_take       = w_resp & ~r_kill & ~bus.override;
    // The fault entry waits for any killed response to drain first.
    assign w_fpush      = r_fpend & ~r_kill & ~bus.override;
    assign w_pop        = bus.out_ready & ~bus.override;
    assign w_stopped_nx = bus.override ? w_mis : r_stopped;
    assign w_pc_nx      = bus.override ? bus.newpc : w_take ? r_addr + 32'd4 : r_pc;
    assign w_entry      = w_fpush ? {NOP_INSTR, r_pc, 1'b1} : {bus.imem_rdata, r_addr, 1'b0};

    fetch_queue u_queue (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_take | w_fpush),
        .i_pop        (w_pop),
        .i_flush      (bus.override),
        .i_entry      (w_entry),
        .o_count_next (w_count_nx),
        .o_valid      (w_head_valid),
        .o_head       (w_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_addr    <= RESET_PC;
            r_pc      <= RESET_PC;
            r_kill    <= 1'b0;
            r_stopped <= 1'b0;
            r_fpend   <= 1'b0;
        end else begin
            r_valid   <= w_hold | (~w_stopped_nx & (w_count_nx < 2'd2));
            r_addr    <= w_hold ? r_addr : w_pc_nx;
            r_pc      <= w_pc_nx;
            r_kill    <= bus.override ? w_hold : r_kill & ~w_resp;
            r_stopped <= w_stopped_nx;
            r_fpend   <= bus.override ? w_mis : r_fpend & ~w_fpush;
        end
    end

    assign bus.imem_valid = r_valid;
    assign bus.imem_addr  = r_addr;
    assign bus.out_valid  = w_head_valid;
    assign bus.out_instr  = w_head.instr;
    assign bus.out_pc     = w_head.pc;
    assign bus.out_fault  = w_head.fault;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus a randomized run checked against a
// stream-level model (each redirect starts a fresh sequential or fault stream).
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0001_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    fetch_unit_if io();
    fetch_unit dut (.clk(clk), .rst(rst), .bus(io));

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic step();
        @(negedge clk);
        io.imem_rdata = mem_word(io.imem_addr);
    endtask

    task automatic do_reset();
        rst = 1'b1; io.override = 1'b0; io.newpc = '0; io.imem_ready = 1'b0; io.out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; io.override = 1'b0; io.newpc = '0; io.imem_ready = 1'b1; io.out_ready = 1'b1;
        step(); step();
        checks++;
        if (io.imem_valid !== 1'b0 || io.imem_addr !== RST_PC) begin
            failures++; $display("FAIL reset_imem got valid=%b addr=%h exp valid=0 addr=%h", io.imem_valid, io.imem_addr, RST_PC);
        end
        checks++;
        if (io.out_valid !== 1'b0 || io.out_instr !== 32'h0 || io.out_pc !== 32'h0 || io.out_fault !== 1'b0) begin
            failures++; $display("FAIL reset_out got valid=%b instr=%h pc=%h fault=%b exp all zero", io.out_valid, io.out_instr, io.out_pc, io.out_fault);
        end
    endtask

    task automatic test_stream();
        logic [31:0] a;
        do_reset();
        io.imem_ready = 1'b1; io.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            a = RST_PC + 32'(4 * k);
            checks++;
            if (io.imem_valid !== 1'b1 || io.imem_addr !== a) begin
                failures++; $display("FAIL stream_req%0d got valid=%b addr=%h exp valid=1 addr=%h", k, io.imem_valid, io.imem_addr, a);
            end
            checks++;
            if (io.out_valid !== (k > 0) || (k > 0 && (io.out_pc !== a - 4 || io.out_instr !== mem_word(a - 4)))) begin
                failures++; $display("FAIL stream_out%0d got valid=%b pc=%h exp valid=%0d pc=%h", k, io.out_valid, io.out_pc, k > 0, a - 4);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        io.imem_ready = 1'b1; io.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (io.imem_valid !== (k < 2) || (k < 2 && io.imem_addr !== RST_PC + 32'(4 * k))) begin
                failures++; $display("FAIL bp_req%0d got valid=%b addr=%h exp valid=%0d", k, io.imem_valid, io.imem_addr, k < 2);
            end
            checks++;
            if (io.out_valid !== (k > 0) || (k > 0 && io.out_pc !== RST_PC)) begin
                failures++; $display("FAIL bp_out%0d got valid=%b pc=%h exp valid=%0d pc=%h", k, io.out_valid, io.out_pc, k > 0, RST_PC);
            end
        end
        io.out_ready = 1'b1;
        step();
        checks++;
        if (io.imem_valid !== 1'b1 || io.imem_addr !== RST_PC + 8 || io.out_pc !== RST_PC + 4) begin
            failures++; $display("FAIL bp_resume got valid=%b addr=%h pc=%h exp valid=1 addr=%h pc=%h", io.imem_valid, io.imem_addr, io.out_pc, RST_PC + 8, RST_PC + 4);
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        io.imem_ready = 1'b1; io.out_ready = 1'b1;
        step(); step(); step();
        io.imem_ready = 1'b0;
        step();
        io.override = 1'b1; io.newpc = 32'h0002_0000;
        step();
        io.override = 1'b0;
        checks++;
        if (io.imem_valid !== 1'b1 || io.imem_addr !== RST_PC + 8 || io.out_valid !== 1'b0) begin
            failures++; $display("FAIL rw_hold got valid=%b addr=%h out_valid=%b exp 1 %h 0", io.imem_valid, io.imem_addr, io.out_valid, RST_PC + 8);
        end
        step();
        io.imem_ready = 1'b1;
        step();
        checks++;
        if (io.imem_valid !== 1'b1 || io.imem_addr !== 32'h0002_0000 || io.out_valid !== 1'b0) begin
            failures++; $display("FAIL rw_newreq got valid=%b addr=%h out_valid=%b exp 1 00020000 0", io.imem_valid, io.imem_addr, io.out_valid);
        end
        step();
        checks++;
        if (io.out_valid !== 1'b1 || io.out_pc !== 32'h0002_0000 || io.out_instr !== mem_word(32'h0002_0000)) begin
            failures++; $display("FAIL rw_first got valid=%b pc=%h exp 1 00020000", io.out_valid, io.out_pc);
        end
    endtask

    task automatic test_redirect_same_cycle();
        do_reset();
        io.imem_ready = 1'b1; io.out_ready = 1'b1;
        step(); step();
        io.override = 1'b1; io.newpc = 32'h0003_0000;
        step();
        io.override = 1'b0;
        checks++;
        if (io.out_valid !== 1'b0 || io.imem_valid !== 1'b1 || io.imem_addr !== 32'h0003_0000) begin
            failures++; $display("FAIL rs_flush got out_valid=%b valid=%b addr=%h exp 0 1 00030000", io.out_valid, io.imem_valid, io.imem_addr);
        end
        step();
        checks++;
        if (io.out_valid !== 1'b1 || io.out_pc !== 32'h0003_0000) begin
            failures++; $display("FAIL rs_first got valid=%b pc=%h exp 1 00030000", io.out_valid, io.out_pc);
        end
    endtask

    task automatic test_misaligned();
        int n;
        do_reset();
        io.imem_ready = 1'b1; io.out_ready = 1'b0;
        step(); step();
        io.override = 1'b1; io.newpc = 32'h0004_0002;
        step();
        io.override = 1'b0;
        n = 0;
        while (io.out_valid !== 1'b1 && n < 4) begin
            checks++;
            if (io.imem_valid !== 1'b0) begin
                failures++; $display("FAIL mis_noreq got valid=%b exp 0", io.imem_valid);
            end
            step(); n++;
        end
        checks++;
        if (io.out_valid !== 1'b1 || io.out_fault !== 1'b1 || io.out_pc !== 32'h0004_0002 || io.out_instr !== NOP) begin
            failures++; $display("FAIL mis_entry got valid=%b fault=%b pc=%h instr=%h exp 1 1 00040002 %h", io.out_valid, io.out_fault, io.out_pc, io.out_instr, NOP);
        end
        io.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (io.imem_valid !== 1'b0 || io.out_valid !== 1'b0) begin
                failures++; $display("FAIL mis_stopped%0d got valid=%b out_valid=%b exp 0 0", k, io.imem_valid, io.out_valid);
            end
        end
        io.override = 1'b1; io.newpc = 32'h0004_0000;
        step();
        io.override = 1'b0;
        checks++;
        if (io.imem_valid !== 1'b1 || io.imem_addr !== 32'h0004_0000) begin
            failures++; $display("FAIL mis_resume got valid=%b addr=%h exp 1 00040000", io.imem_valid, io.imem_addr);
        end
        step();
        checks++;
        if (io.out_valid !== 1'b1 || io.out_pc !== 32'h0004_0000 || io.out_fault !== 1'b0) begin
            failures++; $display("FAIL mis_resume_out got valid=%b pc=%h fault=%b exp 1 00040000 0", io.out_valid, io.out_pc, io.out_fault);
        end
    endtask

    task automatic test_wrap_and_rst();
        do_reset();
        io.imem_ready = 1'b1; io.out_ready = 1'b1;
        step();
        io.override = 1'b1; io.newpc = 32'hffff_fffc;
        step();
        io.override = 1'b0;
        checks++;
        if (io.imem_valid !== 1'b1 || io.imem_addr !== 32'hffff_fffc) begin
            failures++; $display("FAIL wrap_req got valid=%b addr=%h exp 1 fffffffc", io.imem_valid, io.imem_addr);
        end
        step();
        checks++;
        if (io.imem_addr !== 32'h0 || io.out_valid !== 1'b1 || io.out_pc !== 32'hffff_fffc) begin
            failures++; $display("FAIL wrap_next got addr=%h out_valid=%b pc=%h exp 0 1 fffffffc", io.imem_addr, io.out_valid, io.out_pc);
        end
        io.imem_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        checks++;
        if (io.imem_valid !== 1'b0 || io.out_valid !== 1'b0 || io.imem_addr !== RST_PC) begin
            failures++; $display("FAIL mid_rst got valid=%b out_valid=%b addr=%h exp 0 0 %h", io.imem_valid, io.out_valid, io.imem_addr, RST_PC);
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, fault_pc, prev_addr;
        logic [64:0] got, exp;
        int mode, pops;
        logic prev_hold;
        do_reset();
        exp_pc = RST_PC; fault_pc = '0; prev_addr = '0; mode = 0; pops = 0; prev_hold = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if (prev_hold) begin
                checks++;
                if (io.imem_valid !== 1'b1 || io.imem_addr !== prev_addr) begin
                    failures++; $display("FAIL rnd_hold cyc=%0d got valid=%b addr=%h exp 1 %h", cyc, io.imem_valid, io.imem_addr, prev_addr);
                end
            end
            io.override   = ($urandom_range(0, 39) == 0);
            io.newpc      = 32'h0005_0000 + 32'($urandom_range(0, 1023) << 2) + (($urandom_range(0, 4) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            io.out_ready  = ($urandom_range(0, 3) != 0);
            io.imem_ready = ($urandom_range(0, 2) == 0);
            prev_hold = io.imem_valid && !io.imem_ready;
            prev_addr = io.imem_addr;
            if (io.out_valid && io.out_ready && !io.override) begin
                pops++;
                got = {io.out_instr, io.out_pc, io.out_fault};
                exp = (mode == 1) ? {NOP, fault_pc, 1'b1} : {mem_word(exp_pc), exp_pc, 1'b0};
                checks++;
                if (mode == 2 || got !== exp) begin
                    failures++; $display("FAIL rnd_pop cyc=%0d mode=%0d got %h exp %h", cyc, mode, got, exp);
                end
                if (mode == 1) mode = 2;
                else exp_pc = exp_pc + 4;
            end
            if (io.override) begin
                exp_pc = io.newpc; fault_pc = io.newpc;
                mode = (io.newpc[1:0] != 2'b00) ? 1 : 0;
            end
        end
        io.override = 1'b0;
        step();
        checks++;
        if (pops < 200) begin
            failures++; $display("FAIL rnd_throughput got pops=%0d exp >=200", pops);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_same_cycle();
        test_misaligned();
        test_wrap_and_rst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
